// File: rtl/pipe_hazard_unit.sv
// Hazard/forwarding/stall controller beside decode: zero-latency combinational controls from tracked stage state.
// No handshake; hold freezes all state and forces stall, a load-use hazard stalls IF/ID and bubbles ID/EX.
module pipe_hazard_unit #(
   parameter int REG_AW   = 5,
   parameter int DEPTH    = 3,
   parameter int LOAD_RDY = 1,
   parameter int CNT_W    = 16,
   parameter int SELW     = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              hold,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_use_rs,
   input  logic              id_use_rt,
   input  logic [REG_AW-1:0] id_dst,
   input  logic              id_wen,
   input  logic              id_is_load,
   input  logic              redirect,
   output logic              stall,
   output logic              bubble,
   output logic              flush_ifid,
   output logic [SELW-1:0]   fwd_rs,
   output logic [SELW-1:0]   fwd_rt,
   output logic [CNT_W-1:0]  stall_cnt
);

   logic [DEPTH-1:0]  v_q;
   logic [DEPTH-1:0]  wen_q;
   logic [DEPTH-1:0]  ld_q;
   logic [REG_AW-1:0] dst_q [DEPTH];

   logic late_rs;
   logic late_rt;
   logic load_use;

   // Scan oldest to youngest so the youngest producer overwrites the select last.
   always_comb begin
      fwd_rs  = '0;
      fwd_rt  = '0;
      late_rs = 1'b0;
      late_rt = 1'b0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         if (v_q[k] && wen_q[k] && dst_q[k] == id_rs && id_rs != '0) begin
            fwd_rs  = SELW'(k + 1);
            late_rs = ld_q[k] && (k < LOAD_RDY);
         end
         if (v_q[k] && wen_q[k] && dst_q[k] == id_rt && id_rt != '0) begin
            fwd_rt  = SELW'(k + 1);
            late_rt = ld_q[k] && (k < LOAD_RDY);
         end
      end
   end

   assign load_use   = id_valid && ((id_use_rs && late_rs) || (id_use_rt && late_rt));
   assign stall      = hold || load_use;
   assign bubble     = load_use && !hold;
   assign flush_ifid = redirect && !stall;

   always_ff @(posedge clk) begin
      if (rst) begin
         v_q       <= '0;
         stall_cnt <= '0;
      end else if (!hold) begin
         v_q[0] <= id_valid && !bubble;
         for (int k = 1; k < DEPTH; k++) begin
            v_q[k] <= v_q[k-1];
         end
         if (load_use && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
         end
      end
   end

   // Payload fields are qualified by v_q, so they need no reset.
   always_ff @(posedge clk) begin
      if (!hold) begin
         dst_q[0] <= id_dst;
         wen_q[0] <= id_wen;
         ld_q[0]  <= id_is_load;
         for (int k = 1; k < DEPTH; k++) begin
            dst_q[k] <= dst_q[k-1];
            wen_q[k] <= wen_q[k-1];
            ld_q[k]  <= ld_q[k-1];
         end
      end
   end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed scenarios with literal expectations, then randomized traffic checked every cycle against a pipeline model.
module tb_pipe_hazard_unit;
   localparam int AW = 5;
   localparam int D  = 3;
   localparam int LR = 1;
   localparam int CW = 2;
   localparam int SW = $clog2(D + 1);
   localparam int CNT_MAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst, hold, id_valid, id_use_rs, id_use_rt, id_wen, id_is_load, redirect;
   logic [AW-1:0] id_rs, id_rt, id_dst;
   logic          stall, bubble, flush_ifid;
   logic [SW-1:0] fwd_rs, fwd_rt;
   logic [CW-1:0] stall_cnt;

   pipe_hazard_unit #(.REG_AW(AW), .DEPTH(D), .LOAD_RDY(LR), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .hold(hold), .id_valid(id_valid),
      .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
      .id_dst(id_dst), .id_wen(id_wen), .id_is_load(id_is_load), .redirect(redirect),
      .stall(stall), .bubble(bubble), .flush_ifid(flush_ifid),
      .fwd_rs(fwd_rs), .fwd_rt(fwd_rt), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   // In-flight instruction record; index 0 is the youngest (EX).
   typedef struct {
      bit v;
      int dst;
      bit wen;
      bit ld;
   } slot_t;

   slot_t m [D];
   int    mcnt = 0;
   bit    model_ok = 1'b0;
   int    n_chk = 0;
   int    n_fail = 0;

   task automatic chk(input string name, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   function automatic int source_sel(input int r);
      if (r == 0) return 0;
      for (int k = 0; k < D; k++)
         if (m[k].v && m[k].wen && m[k].dst == r) return k + 1;
      return 0;
   endfunction

   function automatic bit not_ready(input int sel);
      if (sel == 0) return 1'b0;
      return m[sel-1].ld && (sel - 1 < LR);
   endfunction

   function automatic void model_eval(output int frs, output int frt, output bit st,
                                      output bit bub, output bit fl);
      bit lu;
      frs = source_sel(int'(id_rs));
      frt = source_sel(int'(id_rt));
      lu  = id_valid && ((id_use_rs && not_ready(frs)) || (id_use_rt && not_ready(frt)));
      st  = hold || lu;
      bub = lu && !hold;
      fl  = redirect && !st;
   endfunction

   always @(posedge clk) begin
      int frs, frt;
      bit st, bub, fl;
      model_eval(frs, frt, st, bub, fl);
      if (rst) begin
         for (int k = 0; k < D; k++) m[k].v = 1'b0;
         mcnt     = 0;
         model_ok = 1'b1;
      end else if (!hold) begin
         if (st && mcnt < CNT_MAX) mcnt = mcnt + 1;
         for (int k = D - 1; k > 0; k--) m[k] = m[k-1];
         m[0] = '{v: id_valid && !bub, dst: int'(id_dst), wen: id_wen, ld: id_is_load};
      end
   end

   always @(negedge clk) begin
      int frs, frt;
      bit st, bub, fl;
      if (model_ok) begin
         model_eval(frs, frt, st, bub, fl);
         chk("m_stall", int'(stall), int'(st));
         chk("m_bubble", int'(bubble), int'(bub));
         chk("m_flush", int'(flush_ifid), int'(fl));
         chk("m_fwd_rs", int'(fwd_rs), frs);
         chk("m_fwd_rt", int'(fwd_rt), frt);
         chk("m_cnt", int'(stall_cnt), mcnt);
      end
   end

   task automatic issue(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                        input int dst, input bit wen, input bit ld, input bit hd, input bit rd);
      @(posedge clk);
      #1;
      id_valid = v;  id_rs = AW'(rs); id_rt = AW'(rt);
      id_use_rs = urs; id_use_rt = urt;
      id_dst = AW'(dst); id_wen = wen; id_is_load = ld;
      hold = hd; redirect = rd;
      @(negedge clk);
   endtask

   initial begin
      for (int k = 0; k < D; k++) m[k] = '{v: 1'b0, dst: 0, wen: 1'b0, ld: 1'b0};
      rst = 1'b1; hold = 1'b0; redirect = 1'b0;
      id_valid = 1'b0; id_rs = '0; id_rt = '0; id_use_rs = 1'b0; id_use_rt = 1'b0;
      id_dst = '0; id_wen = 1'b0; id_is_load = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_stall", int'(stall), 0);
      chk("rst_bubble", int'(bubble), 0);
      chk("rst_flush", int'(flush_ifid), 0);
      chk("rst_fwd_rs", int'(fwd_rs), 0);
      chk("rst_fwd_rt", int'(fwd_rt), 0);
      chk("rst_cnt", int'(stall_cnt), 0);
      rst = 1'b0;

      // ALU forwarding: add r3, then readers of r3
      issue(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
      issue(1, 3, 1, 1, 0, 6, 1, 0, 0, 0);
      chk("alu_fwd1", int'(fwd_rs), 1);
      chk("alu_nostall", int'(stall), 0);
      issue(1, 3, 2, 1, 1, 8, 1, 0, 0, 0);
      chk("alu_fwd2", int'(fwd_rs), 2);

      // Load-use: lw r5, then add reading r5 as rt
      issue(1, 0, 0, 0, 0, 5, 1, 1, 0, 0);
      issue(1, 1, 5, 0, 1, 7, 1, 0, 0, 0);
      chk("lu_stall", int'(stall), 1);
      chk("lu_bubble", int'(bubble), 1);
      chk("lu_fwd_rt1", int'(fwd_rt), 1);
      chk("lu_cnt0", int'(stall_cnt), 0);
      issue(1, 1, 5, 0, 1, 7, 1, 0, 0, 0);
      chk("lu_release", int'(stall), 0);
      chk("lu_fwd_rt2", int'(fwd_rt), 2);
      chk("lu_cnt1", int'(stall_cnt), 1);

      // Youngest producer wins
      issue(1, 0, 0, 0, 0, 4, 1, 0, 0, 0);
      issue(1, 0, 0, 0, 0, 4, 1, 0, 0, 0);
      issue(1, 4, 0, 1, 0, 9, 1, 0, 0, 0);
      chk("young_fwd", int'(fwd_rs), 1);

      // r0 never forwards or stalls, even from a load
      issue(1, 0, 0, 0, 0, 0, 1, 1, 0, 0);
      issue(1, 0, 0, 1, 1, 2, 1, 0, 0, 0);
      chk("r0_fwd_rs", int'(fwd_rs), 0);
      chk("r0_fwd_rt", int'(fwd_rt), 0);
      chk("r0_stall", int'(stall), 0);

      // Redirect: clean flush, then suppressed under a load-use stall and retried
      issue(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      chk("redir_flush", int'(flush_ifid), 1);
      issue(1, 0, 0, 0, 0, 9, 1, 1, 0, 0);
      issue(1, 9, 0, 1, 0, 0, 0, 0, 0, 1);
      chk("redir_stall", int'(stall), 1);
      chk("redir_noflush", int'(flush_ifid), 0);
      issue(1, 9, 0, 1, 0, 0, 0, 0, 0, 1);
      chk("redir_retry", int'(flush_ifid), 1);
      chk("redir_cnt", int'(stall_cnt), 2);

      // Hold freezes state and counter, then saturation of the 2-bit counter
      issue(1, 0, 0, 0, 0, 10, 1, 1, 0, 0);
      repeat (3) begin
         issue(1, 10, 0, 1, 0, 12, 1, 0, 1, 0);
         chk("hold_stall", int'(stall), 1);
         chk("hold_bubble", int'(bubble), 0);
         chk("hold_fwd", int'(fwd_rs), 1);
         chk("hold_cnt", int'(stall_cnt), 2);
      end
      issue(1, 10, 0, 1, 0, 12, 1, 0, 0, 0);
      chk("unhold_bubble", int'(bubble), 1);
      issue(1, 10, 0, 1, 0, 12, 1, 0, 0, 0);
      chk("unhold_fwd", int'(fwd_rs), 2);
      repeat (4) begin
         issue(1, 0, 0, 0, 0, 11, 1, 1, 0, 0);
         issue(1, 11, 11, 1, 1, 13, 1, 0, 0, 0);
         chk("sat_stall", int'(stall), 1);
         issue(1, 11, 11, 1, 1, 13, 1, 0, 0, 0);
      end
      chk("sat_cnt", int'(stall_cnt), 3);

      // Reset pulse clears counter and all selects
      issue(1, 0, 0, 0, 0, 11, 1, 1, 0, 0);
      rst = 1'b1;
      issue(1, 11, 11, 1, 1, 13, 1, 0, 0, 0);
      chk("prst_fwd_rs", int'(fwd_rs), 0);
      chk("prst_fwd_rt", int'(fwd_rt), 0);
      chk("prst_stall", int'(stall), 0);
      chk("prst_cnt", int'(stall_cnt), 0);
      rst = 1'b0;

      // Randomized traffic over a small register range to provoke hazards
      repeat (3000) begin
         @(posedge clk);
         #1;
         rst        = ($urandom % 50) == 0;
         hold       = ($urandom % 8) == 0;
         redirect   = ($urandom % 4) == 0;
         id_valid   = ($urandom % 5) != 0;
         id_rs      = AW'($urandom_range(0, 7));
         id_rt      = AW'($urandom_range(0, 7));
         id_use_rs  = $urandom % 2;
         id_use_rt  = $urandom % 2;
         id_dst     = AW'($urandom_range(0, 7));
         id_wen     = ($urandom % 4) != 0;
         id_is_load = ($urandom % 3) == 0;
      end
      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
